rf_ctrl: RTL and testbench

RF_CTRL -- requirements
Module: rf_ctrl

---
 rtl/rf_ctrl.sv | 108 ++++++++++
 tb/tb_rf_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_ctrl.sv
// 32x32 register file with a self-initialising INIT sequence and a
// two-requester round-robin arbiter sharing the single write port.
module rf_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  Address1,
    input  logic [4:0]  Address2,
    output logic [31:0] Source1,
    output logic [31:0] Source2,
    input  logic        wr_req0,
    input  logic        wr_req1,
    input  logic [4:0]  wr_addr0,
    input  logic [4:0]  wr_addr1,
    input  logic [31:0] wr_data0,
    input  logic [31:0] wr_data1,
    output logic        wr_gnt0,
    output logic        wr_gnt1,
    output logic        ready
);

    typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

    typedef struct packed {
        logic        req;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_req_t;

    localparam logic [31:0] INIT_TABLE [32] = '{
        32'd21,   32'd444,  32'd178,  32'd365,  32'd33,   32'd89,   32'd49,   32'd11,
        32'd347,  32'd44,   32'd1000, 32'd2000, 32'd71,   32'd38,   32'd19,   32'd51,
        32'd663,  32'd1871, 32'd364,  32'd1110, 32'd197,  32'd180,  32'd1,    32'd619,
        32'd42,   32'd43,   32'd831,  32'd39,   32'd734,  32'd92,   32'd3456, 32'd1234
    };

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic        ptr;
    logic [1:0]  gnt;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] regs [32];
    wr_req_t     rq [2];

    assign rq[0] = '{req: wr_req0, addr: wr_addr0, data: wr_data0};
    assign rq[1] = '{req: wr_req1, addr: wr_addr1, data: wr_data1};

    always_comb begin
        state_nxt = state;
        gnt       = 2'b00;
        we        = 1'b0;
        waddr     = cnt;
        wdata     = INIT_TABLE[cnt];
        case (state)
            INIT: begin
                we = 1'b1;
                if (cnt == 5'd31)
                    state_nxt = RUN;
            end
            RUN: begin
                // Contention goes to ptr; a lone requester wins regardless of ptr.
                if (rq[0].req && rq[1].req)
                    gnt = ptr ? 2'b10 : 2'b01;
                else
                    gnt = {rq[1].req, rq[0].req};
                if (gnt[1]) begin
                    we    = 1'b1;
                    waddr = rq[1].addr;
                    wdata = rq[1].data;
                end else if (gnt[0]) begin
                    we    = 1'b1;
                    waddr = rq[0].addr;
                    wdata = rq[0].data;
                end
            end
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            cnt   <= 5'd0;
            ptr   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == INIT)
                cnt <= cnt + 5'd1;
            // Pointer moves to the loser: granting 0 points at 1 and vice versa.
            if (gnt != 2'b00)
                ptr <= gnt[0];
        end
    end

    // Storage is deliberately not reset; INIT rewrites every entry.
    always_ff @(posedge clk) begin
        if (!rst && we)
            regs[waddr] <= wdata;
    end

    assign wr_gnt0 = gnt[0];
    assign wr_gnt1 = gnt[1];
    assign ready   = (state == RUN);
    assign Source1 = (state == RUN) ? regs[Address1] : 32'd0;
    assign Source2 = (state == RUN) ? regs[Address2] : 32'd0;

endmodule

// File: tb/tb_rf_ctrl.sv
// Directed bench for rf_ctrl: init sequence, arbitration, reset behaviour.
module tb_rf_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  Address1, Address2;
    logic [31:0] Source1, Source2;
    logic        wr_req0, wr_req1;
    logic [4:0]  wr_addr0, wr_addr1;
    logic [31:0] wr_data0, wr_data1;
    logic        wr_gnt0, wr_gnt1;
    logic        ready;

    int vectors = 0;
    int errors  = 0;

    logic [31:0] exp_tab [32] = '{
        32'd21,   32'd444,  32'd178,  32'd365,  32'd33,   32'd89,   32'd49,   32'd11,
        32'd347,  32'd44,   32'd1000, 32'd2000, 32'd71,   32'd38,   32'd19,   32'd51,
        32'd663,  32'd1871, 32'd364,  32'd1110, 32'd197,  32'd180,  32'd1,    32'd619,
        32'd42,   32'd43,   32'd831,  32'd39,   32'd734,  32'd92,   32'd3456, 32'd1234
    };

    rf_ctrl dut (
        .clk(clk), .rst(rst),
        .Address1(Address1), .Address2(Address2),
        .Source1(Source1), .Source2(Source2),
        .wr_req0(wr_req0), .wr_req1(wr_req1),
        .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
        .wr_data0(wr_data0), .wr_data1(wr_data1),
        .wr_gnt0(wr_gnt0), .wr_gnt1(wr_gnt1),
        .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Applies one reset edge then counts edges until ready, bounded.
    task automatic do_init(input string name);
        int n;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n = 0;
        while (!ready && n < 100) begin
            tick();
            n++;
        end
        vectors++;
        if (n !== 32) begin
            errors++;
            $display("FAIL %s_init_edges: got %0d expected 32", name, n);
        end
    endtask

    task automatic test_reset();
        wr_req0 = 1'b1; wr_req1 = 1'b1;
        wr_addr0 = 5'd4; wr_addr1 = 5'd6;
        wr_data0 = 32'h1111; wr_data1 = 32'h2222;
        Address1 = 5'd10; Address2 = 5'd31;
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if ({ready, wr_gnt0, wr_gnt1} !== 3'b000 || Source1 !== 0 || Source2 !== 0) begin
            errors++;
            $display("FAIL reset_state: rdy/g0/g1=%b S1=%0d S2=%0d expected 000 0 0",
                     {ready, wr_gnt0, wr_gnt1}, Source1, Source2);
        end
        wr_req0 = 1'b0; wr_req1 = 1'b0;
        do_init("reset");
        vectors++;
        if (Source1 !== 32'd1000 || Source2 !== 32'd1234) begin
            errors++;
            $display("FAIL reset_readback: S1=%0d S2=%0d expected 1000 1234", Source1, Source2);
        end
        for (int i = 0; i < 32; i++) begin
            Address1 = i[4:0];
            Address2 = 5'(31 - i);
            #1;
            vectors++;
            if (Source1 !== exp_tab[i] || Source2 !== exp_tab[31-i]) begin
                errors++;
                $display("FAIL init_table[%0d]: S1=%0d S2=%0d expected %0d %0d",
                         i, Source1, Source2, exp_tab[i], exp_tab[31-i]);
            end
        end
    endtask

    task automatic test_init_requests();
        int n;
        int bad;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wr_req0 = 1'b1; wr_addr0 = 5'd3; wr_data0 = 32'd0;
        Address1 = 5'd3;
        n = 0; bad = 0;
        while (!ready && n < 100) begin
            if (wr_gnt0 !== 1'b0 || wr_gnt1 !== 1'b0 || Source1 !== 32'd0) bad++;
            tick();
            n++;
        end
        wr_req0 = 1'b0;
        #1;
        vectors++;
        if (bad !== 0 || n !== 32) begin
            errors++;
            $display("FAIL init_ignore_req: bad_cycles=%0d edges=%0d expected 0 32", bad, n);
        end
        vectors++;
        if (Source1 !== 32'd365) begin
            errors++;
            $display("FAIL init_reg3: got %0d expected 365", Source1);
        end
    endtask

    task automatic test_single();
        Address1 = 5'd5;
        wr_req0 = 1'b1; wr_addr0 = 5'd5; wr_data0 = 32'hDEADBEEF;
        #1;
        vectors++;
        if (wr_gnt0 !== 1'b1 || wr_gnt1 !== 1'b0 || Source1 !== 32'd89) begin
            errors++;
            $display("FAIL single_same_cycle: g0=%b g1=%b S1=%0d expected 1 0 89",
                     wr_gnt0, wr_gnt1, Source1);
        end
        tick();
        wr_req0 = 1'b0;
        #1;
        vectors++;
        if (Source1 !== 32'hDEADBEEF || wr_gnt0 !== 1'b0) begin
            errors++;
            $display("FAIL single_next_cycle: S1=%h g0=%b expected deadbeef 0", Source1, wr_gnt0);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        do_init("rr");
        wr_req0 = 1'b1; wr_addr0 = 5'd1; wr_data0 = 32'd7;
        wr_req1 = 1'b1; wr_addr1 = 5'd2; wr_data1 = 32'd9;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++;
            if ({wr_gnt1, wr_gnt0} !== exp_g[i]) begin
                errors++;
                $display("FAIL rr_grant[%0d]: g1g0=%b expected %b", i, {wr_gnt1, wr_gnt0}, exp_g[i]);
            end
            tick();
        end
        wr_req0 = 1'b0; wr_req1 = 1'b0;
        Address1 = 5'd1; Address2 = 5'd2;
        #1;
        vectors++;
        if (Source1 !== 32'd7 || Source2 !== 32'd9) begin
            errors++;
            $display("FAIL rr_data: reg1=%0d reg2=%0d expected 7 9", Source1, Source2);
        end
    endtask

    // After the round-robin run ptr=0; a lone req1 must still win immediately.
    task automatic test_alternate();
        logic [1:0] req_seq [3] = '{2'b10, 2'b01, 2'b10};
        logic [4:0] adr_seq [3] = '{5'd7, 5'd8, 5'd9};
        for (int i = 0; i < 3; i++) begin
            {wr_req1, wr_req0} = req_seq[i];
            wr_addr0 = adr_seq[i]; wr_addr1 = adr_seq[i];
            wr_data0 = 32'd100 + i; wr_data1 = 32'd200 + i;
            #1;
            vectors++;
            if ({wr_gnt1, wr_gnt0} !== req_seq[i]) begin
                errors++;
                $display("FAIL alt_grant[%0d]: g1g0=%b expected %b", i, {wr_gnt1, wr_gnt0}, req_seq[i]);
            end
            tick();
        end
        wr_req0 = 1'b0; wr_req1 = 1'b0;
        Address1 = 5'd7; Address2 = 5'd8;
        #1;
        vectors++;
        if (Source1 !== 32'd200 || Source2 !== 32'd101) begin
            errors++;
            $display("FAIL alt_data: reg7=%0d reg8=%0d expected 200 101", Source1, Source2);
        end
        Address1 = 5'd9;
        #1;
        vectors++;
        if (Source1 !== 32'd202) begin
            errors++;
            $display("FAIL alt_data9: got %0d expected 202", Source1);
        end
    endtask

    // Consecutive writes, including address 0, with no idle cycles.
    task automatic test_back_to_back();
        logic [4:0]  adr [3] = '{5'd0, 5'd20, 5'd21};
        logic [31:0] dat [3] = '{32'hA5A5_0000, 32'h0000_5A5A, 32'h1234_5678};
        Address1 = 5'd0;
        #1;
        vectors++;
        if (Source1 !== 32'd21) begin
            errors++;
            $display("FAIL b2b_reg0_before: got %0d expected 21", Source1);
        end
        for (int i = 0; i < 3; i++) begin
            wr_req0 = 1'b1; wr_addr0 = adr[i]; wr_data0 = dat[i];
            #1;
            vectors++;
            if (wr_gnt0 !== 1'b1) begin
                errors++;
                $display("FAIL b2b_grant[%0d]: got %b expected 1", i, wr_gnt0);
            end
            tick();
        end
        wr_req0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            Address2 = adr[i];
            #1;
            vectors++;
            if (Source2 !== dat[i]) begin
                errors++;
                $display("FAIL b2b_data[%0d]: got %h expected %h", i, Source2, dat[i]);
            end
        end
    endtask

    task automatic test_rst_mid_run();
        wr_req0 = 1'b1; wr_addr0 = 5'd12; wr_data0 = 32'd55;
        Address1 = 5'd12;
        #1;
        vectors++;
        if (wr_gnt0 !== 1'b1) begin
            errors++;
            $display("FAIL midrst_grant: got %b expected 1", wr_gnt0);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wr_req0 = 1'b0;
        #1;
        vectors++;
        if (ready !== 1'b0 || Source1 !== 32'd0 || wr_gnt0 !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state: rdy=%b S1=%0d g0=%b expected 0 0 0", ready, Source1, wr_gnt0);
        end
        begin
            int n = 0;
            while (!ready && n < 100) begin
                tick();
                n++;
            end
            vectors++;
            if (n !== 32) begin
                errors++;
                $display("FAIL midrst_edges: got %0d expected 32", n);
            end
        end
        vectors++;
        if (Source1 !== 32'd71) begin
            errors++;
            $display("FAIL midrst_reg12: got %0d expected 71", Source1);
        end
    endtask

    initial begin
        rst = 1'b1;
        wr_req0 = 1'b0; wr_req1 = 1'b0;
        wr_addr0 = '0; wr_addr1 = '0; wr_data0 = '0; wr_data1 = '0;
        Address1 = '0; Address2 = '0;
        test_reset();
        test_init_requests();
        test_single();
        test_round_robin();
        test_alternate();
        test_back_to_back();
        test_rst_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
